// File: rtl/led_register_bank_pkg.sv
// Shared constants, types and helpers for the LED register bank.
package led_register_bank_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 13;

  // Fixed register map
  localparam logic [BYTE_W-1:0] ADDR_MODE1        = 8'h00;
  localparam logic [BYTE_W-1:0] ADDR_MODE2        = 8'h01;
  localparam logic [BYTE_W-1:0] ADDR_ALL_LED      = 8'hFA;
  localparam logic [BYTE_W-1:0] ADDR_ALL_LED_LAST = 8'hFD;
  localparam logic [BYTE_W-1:0] ADDR_PRESCALE     = 8'hFE;
  localparam logic [BYTE_W-1:0] ADDR_MAX          = 8'hFF;

  // MODE register bit positions
  localparam int unsigned MODE1_AI_BIT    = 5;
  localparam int unsigned MODE1_SLEEP_BIT = 4;
  localparam int unsigned MODE2_OCH_BIT   = 3;

  // Reset values
  localparam logic [BYTE_W-1:0] MODE1_RST    = 8'h11;
  localparam logic [BYTE_W-1:0] MODE2_RST    = 8'h04;
  localparam logic [BYTE_W-1:0] PRESCALE_RST = 8'h1E;
  localparam logic [BYTE_W-1:0] PRESCALE_MIN = 8'h03;

  // One channel's {ON, OFF} pair; each is {full bit, 12-bit count}
  typedef struct packed {
    logic [CNT_W-1:0] on;
    logic [CNT_W-1:0] off;
  } led_cnt_t;

  // Channel reset: ON=0, OFF full-off
  localparam led_cnt_t CNT_RST = {13'h0000, 13'h1000};

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } xfer_state_e;

  // Pointer auto-increment with wrap after the last channel byte and 0xFF
  function automatic logic [BYTE_W-1:0] next_ptr(input logic [BYTE_W-1:0] addr,
                                                 input logic [BYTE_W-1:0] last_ch_addr);
    if (addr == last_ch_addr || addr == ADDR_MAX) return 8'h00;
    return addr + 8'd1;
  endfunction

endpackage

// File: rtl/led_register_bank_if.sv
// Host write/read bus of the LED register bank.
interface led_register_bank_if;
  import led_register_bank_pkg::*;

  logic              start_i;
  logic [BYTE_W-1:0] addr_i;
  logic              wr_en_i;
  logic [BYTE_W-1:0] wr_data_i;
  logic              stop_i;
  logic [BYTE_W-1:0] rd_addr_i;
  logic [BYTE_W-1:0] rd_data_o;

  modport master (
    output start_i, addr_i, wr_en_i, wr_data_i, stop_i, rd_addr_i,
    input  rd_data_o
  );

  modport slave (
    input  start_i, addr_i, wr_en_i, wr_data_i, stop_i, rd_addr_i,
    output rd_data_o
  );

endinterface

// File: rtl/led_channel_regs.sv
// Staged/live/dirty storage for a single LED channel.
module led_channel_regs
  import led_register_bank_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        byte_we_i,
  input  logic [BYTE_W-1:0] wr_data_i,
  input  logic              commit_i,
  output led_cnt_t          live_o,
  output logic              moved_c
);

  led_cnt_t staged_q, staged_d;
  led_cnt_t live_q, live_d;
  logic     dirty_q, dirty_d;
  logic     wr_any;

  // Byte writes into the staged copy; commit copies staged (incl. this write) to live
  always_comb begin
    staged_d = staged_q;
    if (byte_we_i[0]) staged_d.on[7:0]        = wr_data_i;
    if (byte_we_i[1]) staged_d.on[CNT_W-1:8]  = wr_data_i[4:0];
    if (byte_we_i[2]) staged_d.off[7:0]       = wr_data_i;
    if (byte_we_i[3]) staged_d.off[CNT_W-1:8] = wr_data_i[4:0];
    wr_any  = |byte_we_i;
    moved_c = commit_i && (dirty_q || wr_any);
    dirty_d = commit_i ? 1'b0 : (dirty_q || wr_any);
    live_d  = commit_i ? staged_d : live_q;
  end

  // Channel state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      staged_q <= CNT_RST;
      live_q   <= CNT_RST;
      dirty_q  <= 1'b0;
    end else begin
      staged_q <= staged_d;
      live_q   <= live_d;
      dirty_q  <= dirty_d;
    end
  end

  assign live_o = live_q;

endmodule

// File: rtl/led_register_bank.sv
// Byte-addressed LED PWM register bank with staged channel updates.
module led_register_bank
  import led_register_bank_pkg::*;
#(
  parameter int unsigned       NUM_CH   = 16,
  parameter logic [BYTE_W-1:0] REG_BASE = 8'h06
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  led_register_bank_if.slave      bus,
  output logic [BYTE_W-1:0]       mode1_o,
  output logic [BYTE_W-1:0]       mode2_o,
  output logic [BYTE_W-1:0]       prescale_o,
  output logic [CNT_W*NUM_CH-1:0] on_cnt_o,
  output logic [CNT_W*NUM_CH-1:0] off_cnt_o,
  output logic                    update_o
);

  localparam logic [BYTE_W-1:0] LAST_CH_ADDR = 8'(32'(REG_BASE) + 4 * NUM_CH - 1);
  localparam int unsigned       CH_IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  xfer_state_e       state_q, state_d;
  logic              wr_ok_c;
  logic [BYTE_W-1:0] wr_addr, wr_off, rd_off;
  logic              wr_ch_hit, wr_all_hit;
  logic [1:0]        all_byte;
  logic              och, stop_commit;
  logic [BYTE_W-1:0] ptr_q, ptr_d;
  logic [BYTE_W-1:0] mode1_q, mode1_d, mode2_q, mode2_d, prescale_q, prescale_d;
  logic [BYTE_W-1:0] rd_data_q, rd_data_d;
  logic              update_q, update_d;
  logic [NUM_CH-1:0] moved;
  led_cnt_t [NUM_CH-1:0] live_all;
  led_cnt_t          rd_cnt;

  // Transaction state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Transaction next state: stop ends, start opens
  always_comb begin
    state_d = state_q;
    if (bus.stop_i)       state_d = ST_IDLE;
    else if (bus.start_i) state_d = ST_ACTIVE;
  end

  // Writes are accepted inside a transaction or alongside its start
  always_comb begin
    wr_ok_c = bus.wr_en_i && (bus.start_i || state_q == ST_ACTIVE);
  end

  // Write address decode
  always_comb begin
    wr_addr     = bus.start_i ? bus.addr_i : ptr_q;
    wr_off      = wr_addr - REG_BASE;
    wr_ch_hit   = wr_ok_c && (wr_addr >= REG_BASE) && (wr_addr <= LAST_CH_ADDR);
    wr_all_hit  = wr_ok_c && (wr_addr >= ADDR_ALL_LED) && (wr_addr <= ADDR_ALL_LED_LAST);
    all_byte    = wr_addr[1:0] - 2'd2;
    och         = mode2_q[MODE2_OCH_BIT];
    stop_commit = bus.stop_i && !och;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [3:0] byte_we;
    logic       commit;

    // Per-channel byte enables and commit request
    always_comb begin
      byte_we = '0;
      if (wr_ch_hit && wr_off[7:2] == 6'(c)) byte_we[wr_off[1:0]] = 1'b1;
      if (wr_all_hit)                        byte_we[all_byte]    = 1'b1;
      commit = stop_commit || (och && byte_we[3]);
    end

    led_channel_regs u_regs (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .byte_we_i (byte_we),
      .wr_data_i (bus.wr_data_i),
      .commit_i  (commit),
      .live_o    (live_all[c]),
      .moved_c   (moved[c])
    );

    assign on_cnt_o[c*CNT_W +: CNT_W]  = live_all[c].on;
    assign off_cnt_o[c*CNT_W +: CNT_W] = live_all[c].off;
  end

  // MODE/PRE_SCALE updates, pointer movement and update pulse
  always_comb begin
    mode1_d    = mode1_q;
    mode2_d    = mode2_q;
    prescale_d = prescale_q;
    ptr_d      = ptr_q;
    if (wr_ok_c) begin
      if (wr_addr == ADDR_MODE1) mode1_d = bus.wr_data_i;
      if (wr_addr == ADDR_MODE2) mode2_d = bus.wr_data_i;
      if (wr_addr == ADDR_PRESCALE && mode1_q[MODE1_SLEEP_BIT])
        prescale_d = (bus.wr_data_i < PRESCALE_MIN) ? PRESCALE_MIN : bus.wr_data_i;
      ptr_d = mode1_q[MODE1_AI_BIT] ? next_ptr(wr_addr, LAST_CH_ADDR) : wr_addr;
    end else if (bus.start_i) begin
      ptr_d = bus.addr_i;
    end
    update_d = |moved;
  end

  // Read mux over live values
  always_comb begin
    rd_off = bus.rd_addr_i - REG_BASE;
    rd_cnt = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rd_off[7:2] == 6'(c)) rd_cnt = live_all[CH_IDX_W'(c)];
    end
    rd_data_d = '0;
    if (bus.rd_addr_i == ADDR_MODE1)         rd_data_d = mode1_q;
    else if (bus.rd_addr_i == ADDR_MODE2)    rd_data_d = mode2_q;
    else if (bus.rd_addr_i == ADDR_PRESCALE) rd_data_d = prescale_q;
    else if (bus.rd_addr_i >= REG_BASE && bus.rd_addr_i <= LAST_CH_ADDR) begin
      case (rd_off[1:0])
        2'd0:    rd_data_d = rd_cnt.on[7:0];
        2'd1:    rd_data_d = 8'(rd_cnt.on[CNT_W-1:8]);
        2'd2:    rd_data_d = rd_cnt.off[7:0];
        default: rd_data_d = 8'(rd_cnt.off[CNT_W-1:8]);
      endcase
    end
  end

  // Control and read-data registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      mode1_q    <= MODE1_RST;
      mode2_q    <= MODE2_RST;
      prescale_q <= PRESCALE_RST;
      rd_data_q  <= '0;
      update_q   <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      mode1_q    <= mode1_d;
      mode2_q    <= mode2_d;
      prescale_q <= prescale_d;
      rd_data_q  <= rd_data_d;
      update_q   <= update_d;
    end
  end

  assign bus.rd_data_o = rd_data_q;
  assign mode1_o       = mode1_q;
  assign mode2_o       = mode2_q;
  assign prescale_o    = prescale_q;
  assign update_o      = update_q;

endmodule

// File: tb/tb_led_register_bank.sv
// Scoreboard bench for led_register_bank with a byte-map reference model.
module tb_led_register_bank;
  import led_register_bank_pkg::*;

  localparam int unsigned NCH  = 16;
  localparam logic [7:0]  BASE = 8'h06;
  localparam logic [7:0]  LAST = 8'h45;
  localparam int unsigned VW   = NCH * 13;

  typedef struct packed {
    logic          upd;
    logic [7:0]    rd, m1, m2, ps;
    logic [VW-1:0] on, off;
  } exp_t;

  typedef struct packed {
    logic [VW-1:0] on, off;
  } snap_t;

  logic clk, rst;
  logic [7:0] mode1_o, mode2_o, prescale_o;
  logic [VW-1:0] on_cnt_o, off_cnt_o;
  logic update_o;

  led_register_bank_if bus();

  led_register_bank #(.NUM_CH(NCH), .REG_BASE(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .mode1_o(mode1_o), .mode2_o(mode2_o), .prescale_o(prescale_o),
    .on_cnt_o(on_cnt_o), .off_cnt_o(off_cnt_o), .update_o(update_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  exp_t  exp_q[$];
  snap_t upd_q[$];

  // Reference model: registers as a byte map plus staged/live channel copies
  logic [7:0]  m_mode1, m_mode2, m_ps, m_ptr;
  bit          m_active, m_moved;
  logic [12:0] m_st_on[NCH], m_st_off[NCH], m_lv_on[NCH], m_lv_off[NCH];
  bit          m_dirty[NCH];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [12:0] cnt_of(input logic [VW-1:0] v, input int c);
    return v[c*13 +: 13];
  endfunction

  task automatic model_reset();
    m_mode1 = 8'h11; m_mode2 = 8'h04; m_ps = 8'h1E; m_ptr = 8'h00; m_active = 0;
    for (int c = 0; c < NCH; c++) begin
      m_st_on[c] = 13'h0000; m_st_off[c] = 13'h1000;
      m_lv_on[c] = 13'h0000; m_lv_off[c] = 13'h1000;
      m_dirty[c] = 0;
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    int off;
    if (a == 8'h00) return m_mode1;
    if (a == 8'h01) return m_mode2;
    if (a == 8'hFE) return m_ps;
    if (a >= BASE && a <= LAST) begin
      off = int'(a) - int'(BASE);
      case (off % 4)
        0: return m_lv_on[off/4][7:0];
        1: return {3'b000, m_lv_on[off/4][12:8]};
        2: return m_lv_off[off/4][7:0];
        default: return {3'b000, m_lv_off[off/4][12:8]};
      endcase
    end
    return 8'h00;
  endfunction

  task automatic commit_ch(input int c);
    if (m_dirty[c]) begin
      m_lv_on[c] = m_st_on[c]; m_lv_off[c] = m_st_off[c];
      m_dirty[c] = 0; m_moved = 1;
    end
  endtask

  task automatic set_byte(input int c, input int k, input logic [7:0] d);
    case (k)
      0: m_st_on[c][7:0]   = d;
      1: m_st_on[c][12:8]  = d[4:0];
      2: m_st_off[c][7:0]  = d;
      default: m_st_off[c][12:8] = d[4:0];
    endcase
    m_dirty[c] = 1;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d, input bit och, input bit sleep);
    int off, k;
    if (a >= BASE && a <= LAST) begin
      off = int'(a) - int'(BASE);
      set_byte(off / 4, off % 4, d);
      if (off % 4 == 3 && och) commit_ch(off / 4);
    end else if (a >= 8'hFA && a <= 8'hFD) begin
      k = int'(a) - 'hFA;
      for (int c = 0; c < NCH; c++) set_byte(c, k, d);
      if (k == 3 && och) for (int c = 0; c < NCH; c++) commit_ch(c);
    end else if (a == 8'h00) m_mode1 = d;
    else if (a == 8'h01) m_mode2 = d;
    else if (a == 8'hFE && sleep) m_ps = (d < 8'h03) ? 8'h03 : d;
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'hFE;
      3: return 8'(8'hFA + $urandom_range(0, 3));
      4: return ($urandom_range(0, 1) == 1) ? LAST : 8'hFF;
      5: return 8'($urandom_range(2, 5) + (($urandom_range(0, 1) == 1) ? 'h44 : 0));
      default: return 8'(int'(BASE) + $urandom_range(0, 63));
    endcase
  endfunction

  // One clock of stimulus; called at a falling edge, returns at the next one
  task automatic step(input bit r, input bit s, input logic [7:0] a, input bit w,
                      input logic [7:0] d, input bit p);
    exp_t e;
    logic [7:0] ra, wa;
    bit och, ai, sleep;
    ra = pick_addr();
    rst = r; bus.start_i = s; bus.addr_i = a; bus.wr_en_i = w;
    bus.wr_data_i = d; bus.stop_i = p; bus.rd_addr_i = ra;
    m_moved = 0;
    if (r) begin
      e.rd = 8'h00;
      model_reset();
    end else begin
      e.rd  = model_read(ra);
      och   = m_mode2[3]; ai = m_mode1[5]; sleep = m_mode1[4];
      wa    = s ? a : m_ptr;
      if (w && (s || m_active)) begin
        model_write(wa, d, och, sleep);
        m_ptr = !ai ? wa : ((wa == LAST || wa == 8'hFF) ? 8'h00 : wa + 8'd1);
      end else if (s) m_ptr = a;
      if (p && !och) for (int c = 0; c < NCH; c++) commit_ch(c);
      if (p) m_active = 0;
      else if (s) m_active = 1;
    end
    e.upd = m_moved; e.m1 = m_mode1; e.m2 = m_mode2; e.ps = m_ps;
    for (int c = 0; c < NCH; c++) begin
      e.on[c*13 +: 13]  = m_lv_on[c];
      e.off[c*13 +: 13] = m_lv_off[c];
    end
    exp_q.push_back(e);
    if (m_moved) upd_q.push_back('{on: e.on, off: e.off});
    @(negedge clk);
  endtask

  task automatic burst(input logic [7:0] a, input logic [31:0] bytes, input int n, input bit do_stop);
    for (int i = 0; i < n; i++) step(0, i == 0, a, 1, bytes[8*i +: 8], 0);
    if (do_stop) step(0, 0, 8'h00, 0, 8'h00, 1);
  endtask

  task automatic wr1(input logic [7:0] a, input logic [7:0] d);
    burst(a, 32'(d), 1, 1);
  endtask

  // Monitor: per-cycle scoreboard plus live snapshot on every update pulse
  initial begin
    exp_t e;
    snap_t sn;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("update_o", 256'(update_o), 256'(e.upd));
        chk("rd_data", 256'(bus.rd_data_o), 256'(e.rd));
        chk("mode1", 256'(mode1_o), 256'(e.m1));
        chk("mode2", 256'(mode2_o), 256'(e.m2));
        chk("prescale", 256'(prescale_o), 256'(e.ps));
        chk("on_cnt", 256'(on_cnt_o), 256'(e.on));
        chk("off_cnt", 256'(off_cnt_o), 256'(e.off));
      end
      if (update_o === 1'b1) begin
        if (upd_q.size() == 0) chk("update_spurious", 256'(update_o), 256'(0));
        else begin
          sn = upd_q.pop_front();
          chk("upd_on", 256'(on_cnt_o), 256'(sn.on));
          chk("upd_off", 256'(off_cnt_o), 256'(sn.off));
        end
      end
    end
  end

  // Directed scenarios, then randomized traffic
  initial begin
    rst = 1; bus.start_i = 0; bus.addr_i = 0; bus.wr_en_i = 0;
    bus.wr_data_i = 0; bus.stop_i = 0; bus.rd_addr_i = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_mode1", 256'(mode1_o), 256'(8'h11));
    chk("rst_mode2", 256'(mode2_o), 256'(8'h04));
    chk("rst_prescale", 256'(prescale_o), 256'(8'h1E));
    chk("rst_off_ch0", 256'(cnt_of(off_cnt_o, 0)), 256'(13'h1000));
    chk("rst_on_ch7", 256'(cnt_of(on_cnt_o, 7)), 256'(13'h0000));
    chk("rst_update", 256'(update_o), 256'(0));

    // Staged burst committed on stop
    wr1(8'h00, 8'h31);
    burst(8'h06, 32'h02340001, 4, 0);
    chk("staged_hidden", 256'(cnt_of(off_cnt_o, 0)), 256'(13'h1000));
    step(0, 0, 0, 0, 0, 1);
    chk("stop_off_ch0", 256'(cnt_of(off_cnt_o, 0)), 256'(13'h0234));
    chk("stop_on_ch0", 256'(cnt_of(on_cnt_o, 0)), 256'(13'h0001));
    chk("stop_update", 256'(update_o), 256'(1));
    step(0, 0, 0, 0, 0, 0);
    chk("update_one_pulse", 256'(update_o), 256'(0));

    // Commit on OFF_H write
    wr1(8'h01, 8'h0C);
    burst(8'h06, 32'h03780005, 3, 0);
    chk("och_before", 256'(cnt_of(off_cnt_o, 0)), 256'(13'h0234));
    step(0, 0, 0, 1, 8'h03, 0);
    chk("och_off_ch0", 256'(cnt_of(off_cnt_o, 0)), 256'(13'h0378));
    chk("och_update", 256'(update_o), 256'(1));
    step(0, 0, 0, 0, 0, 1);
    chk("och_stop_noupd", 256'(update_o), 256'(0));
    wr1(8'h01, 8'h04);

    // ALL_LED broadcast
    burst(8'hFC, 32'h00000FBE, 2, 1);
    for (int c = 0; c < NCH; c++) chk("all_led_off", 256'(cnt_of(off_cnt_o, c)), 256'(13'h0FBE));

    // PRE_SCALE gating and clamp
    wr1(8'h00, 8'h01);
    wr1(8'hFE, 8'h79);
    chk("ps_gated", 256'(prescale_o), 256'(8'h1E));
    wr1(8'h00, 8'h11);
    wr1(8'hFE, 8'h79);
    chk("ps_written", 256'(prescale_o), 256'(8'h79));
    wr1(8'hFE, 8'h01);
    chk("ps_clamp", 256'(prescale_o), 256'(8'h03));
    wr1(8'h00, 8'h31);

    // Wrap from last channel byte and from 0xFF
    burst(LAST, 32'h00002107, 2, 1);
    chk("wrap_last_mode1", 256'(mode1_o), 256'(8'h21));
    chk("wrap_last_ch15", 256'(cnt_of(off_cnt_o, 15)), 256'(13'h07BE));
    burst(8'hFF, 32'h00003355, 2, 1);
    chk("wrap_ff_mode1", 256'(mode1_o), 256'(8'h33));
    wr1(8'h00, 8'h31);

    // Unmapped bytes skipped but pointer advances
    burst(8'h03, 32'h44332211, 4, 1);
    chk("unmapped_skip", 256'(cnt_of(on_cnt_o, 0)), 256'(13'h0044));

    // Reset mid-burst
    burst(8'h0A, 32'h00332211, 3, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("midrst_mode1", 256'(mode1_o), 256'(8'h11));
    chk("midrst_update", 256'(update_o), 256'(0));
    chk("midrst_off_ch1", 256'(cnt_of(off_cnt_o, 1)), 256'(13'h1000));
    chk("midrst_off_ch0", 256'(cnt_of(off_cnt_o, 0)), 256'(13'h1000));
    step(0, 0, 0, 1, 8'h99, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("nostart_ignored", 256'(update_o), 256'(0));

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, pick_addr(),
           $urandom_range(0, 1) == 1, d, $urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    chk("exp_q_drained", 256'(exp_q.size()), 256'(0));
    chk("upd_q_drained", 256'(upd_q.size()), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
